// File: rtl/node_input_sequencer_if.sv
// -----------------------------------------------------------------------------
// node_input_sequencer_if
//   Bundles the two streaming faces of the node input sequencer:
//     - upstream frame stream : in_valid, in_data, in_ready (+ in_last when
//       FRAME_LAST_EN is defined)
//     - node-facing sample bus: node_ready, data_out, cnt_val, data_valid,
//       acc_clr
//   modport master : the sequencer (drives in_ready and the node-facing bus)
//   modport slave  : the environment (upstream source and the node itself)
//   Optional macro: FRAME_LAST_EN adds the in_last frame delimiter.
// -----------------------------------------------------------------------------
interface node_input_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 7
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
`ifdef FRAME_LAST_EN
  logic              in_last;
`endif
  logic              node_ready;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  cnt_val;
  logic              data_valid;
  logic              acc_clr;

  modport master (
`ifdef FRAME_LAST_EN
    input  in_last,
`endif
    input  in_valid, in_data, node_ready,
    output in_ready, data_out, cnt_val, data_valid, acc_clr
  );

  modport slave (
`ifdef FRAME_LAST_EN
    output in_last,
`endif
    output in_valid, in_data, node_ready,
    input  in_ready, data_out, cnt_val, data_valid, acc_clr
  );
endinterface

// File: rtl/node_input_sequencer.sv
// -----------------------------------------------------------------------------
// node_input_sequencer
//   Loads one NUM_INPUTS-sample feature frame from a valid/ready stream into an
//   internal buffer, then sweeps it word-serially to the node datapath with an
//   accumulator-clear pulse before the sweep and a done pulse after it.
//   Flow: IDLE -start-> LOAD (NUM_INPUTS handshakes) -> CLEAR (acc_clr)
//         -> SWEEP (NUM_INPUTS node consumptions) -> DONE (sweep_done) -> IDLE
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   start        begin a frame load; only honoured in IDLE
//   bus          node_input_sequencer_if.master (upstream stream + node bus)
//   busy         high in every state except IDLE
//   sweep_done   one-cycle pulse after the last sample was consumed
//   frame_err    sticky framing error (FRAME_LAST_EN only, else tied 0)
// Optional macro: FRAME_LAST_EN -- frame must be delimited by in_last on the
//   final word; a misplaced or missing in_last aborts the frame to IDLE.
// -----------------------------------------------------------------------------
module node_input_sequencer #(
  parameter int DATA_W     = 16,
  parameter int NUM_INPUTS = 64,
  parameter int CNT_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  node_input_sequencer_if.master bus,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  frame_err
);
  localparam int               ADDR_W   = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, SWEEP, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] frame_buf [NUM_INPUTS];
  logic              in_hs;
  logic              node_hs;
  logic              frame_bad;

  // All strobes are pure decodes of the registered state, so reset clears
  // them asynchronously without waiting for a clock edge.
  assign bus.in_ready   = (state == LOAD);
  assign bus.acc_clr    = (state == CLEAR);
  assign bus.data_valid = (state == SWEEP);
  assign sweep_done     = (state == DONE);
  assign busy           = (state != IDLE);
  assign bus.cnt_val    = cnt_q;
  assign bus.data_out   = data_q;

  assign in_hs   = bus.in_valid & bus.in_ready;
  assign node_hs = bus.data_valid & bus.node_ready;
  assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef FRAME_LAST_EN
  // Well formed only when in_last marks exactly the final word of the frame.
  assign frame_bad = in_hs & (bus.in_last != (wr_cnt == LAST_IDX));
`else
  assign frame_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (frame_bad)                        state_nxt = IDLE;
        else if (in_hs && wr_cnt == LAST_IDX) state_nxt = CLEAR;
      end
      CLEAR:   state_nxt = SWEEP;
      SWEEP:   if (node_hs && cnt_q == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the frame buffer has no reset; every entry is written during LOAD
  // before SWEEP can read it, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (in_hs) frame_buf[wr_cnt[ADDR_W-1:0]] <= bus.in_data;
  end

  // data_q is prefetched together with cnt_q so the sample and its index are
  // presented in the same cycle. After the last consumption cnt_q parks at
  // NUM_INPUTS as the end marker and data_q simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE:  if (start) wr_cnt <= '0;
        LOAD:  if (in_hs) wr_cnt <= wr_cnt + CNT_W'(1);
        CLEAR: begin
          cnt_q  <= '0;
          data_q <= frame_buf[0];
        end
        SWEEP: if (node_hs) begin
          cnt_q <= cnt_inc;
          if (cnt_q != LAST_IDX) data_q <= frame_buf[cnt_inc[ADDR_W-1:0]];
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          frame_err <= 1'b0;
    else if (state == IDLE && start)  frame_err <= 1'b0;
    else if (frame_bad)               frame_err <= 1'b1;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule
